// File: rtl/draw_pkg.sv
// draw_pkg: shared types and constants for the frame draw sequencer.
// State encoding, pass flag and object select codes.
package draw_pkg;

    localparam int NUM_OBJ = 5;

    typedef enum logic [2:0] {
        S_IDLE,
        S_SEL,
        S_LOAD,
        S_DRAW,
        S_UPDATE,
        S_SAMPLE,
        S_FEND
    } state_t;

    typedef enum logic {
        PASS_ERASE,
        PASS_PAINT
    } pass_t;

    localparam logic [3:0] OBJ_NONE   = 4'd0;
    localparam logic [3:0] OBJ_PLAYER = 4'd1;
    localparam logic [3:0] OBJ_E0     = 4'd2;
    localparam logic [3:0] OBJ_E1     = 4'd3;
    localparam logic [3:0] OBJ_E2     = 4'd4;
    localparam logic [3:0] OBJ_E3     = 4'd5;

endpackage

// File: rtl/obj_picker.sv
// obj_picker: lowest-set-bit finder over the object slot mask.
// Ports: mask in; valid out (any bit set); code out (index+1, 0 if none).
module obj_picker
    import draw_pkg::*;
(
    input  logic [NUM_OBJ-1:0] mask,
    output logic               valid,
    output logic [3:0]         code
);

    // Scan from the top down so the lowest set bit is the last to win.
    always_comb begin
        valid = 1'b0;
        code  = OBJ_NONE;
        for (int i = NUM_OBJ - 1; i >= 0; i--) begin
            if (mask[i]) begin
                valid = 1'b1;
                code  = 4'(i + 1);
            end
        end
    end

endmodule

// File: rtl/draw_sequencer.sv
// draw_sequencer: per-frame erase/paint controller for the display handler.
// Ports: clk, reset (sync, active-low), frame_tick, obj_active[4:0],
//   draw_done in; control_signal[3:0], enable_load, enable_draw, erase,
//   game_update, frame_done, busy, overrun, timeout_err out.
module draw_sequencer
    import draw_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 20000
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       frame_tick,
    input  logic [4:0] obj_active,
    input  logic       draw_done,
    output logic [3:0] control_signal,
    output logic       enable_load,
    output logic       enable_draw,
    output logic       erase,
    output logic       game_update,
    output logic       frame_done,
    output logic       busy,
    output logic       overrun,
    output logic       timeout_err
);

    localparam int CW = $clog2(TIMEOUT_CYCLES);
    localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT_CYCLES - 1);

    state_t       state_q, state_d;
    pass_t        pass_q, pass_d;
    logic [4:0]   prev_q, prev_d;
    logic [4:0]   cur_q, cur_d;
    logic [4:0]   todo_q, todo_d;
    logic [3:0]   sel_q, sel_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic         pending_q, pending_d;
    logic         overrun_q, overrun_d;
    logic         tout_q, tout_d;

    logic         pick_valid;
    logic [3:0]   pick_code;

    obj_picker u_picker (
        .mask  (todo_q),
        .valid (pick_valid),
        .code  (pick_code)
    );

    always_comb begin
        state_d        = state_q;
        pass_d         = pass_q;
        prev_d         = prev_q;
        cur_d          = cur_q;
        todo_d         = todo_q;
        sel_d          = sel_q;
        cnt_d          = cnt_q;
        pending_d      = pending_q;
        overrun_d      = overrun_q;
        tout_d         = tout_q;
        control_signal = OBJ_NONE;
        enable_load    = 1'b0;
        enable_draw    = 1'b0;
        game_update    = 1'b0;
        frame_done     = 1'b0;

        // Only one tick is queued; further ticks just flag the overrun.
        if (frame_tick && state_q != S_IDLE) begin
            if (pending_q) begin
                overrun_d = 1'b1;
            end else begin
                pending_d = 1'b1;
            end
        end

        unique case (state_q)
            S_IDLE: begin
                if (frame_tick || pending_q) begin
                    state_d   = S_SEL;
                    pass_d    = PASS_ERASE;
                    todo_d    = prev_q;
                    pending_d = 1'b0;
                end
            end
            S_SEL: begin
                control_signal = pick_code;
                if (pick_valid) begin
                    sel_d   = pick_code;
                    // Clear the lowest set bit, the one just picked.
                    todo_d  = todo_q & (todo_q - 5'd1);
                    state_d = S_LOAD;
                end else if (pass_q == PASS_ERASE) begin
                    state_d = S_UPDATE;
                end else begin
                    state_d = S_FEND;
                end
            end
            S_LOAD: begin
                control_signal = sel_q;
                enable_load    = 1'b1;
                cnt_d          = '0;
                state_d        = S_DRAW;
            end
            S_DRAW: begin
                control_signal = sel_q;
                enable_draw    = 1'b1;
                cnt_d          = cnt_q + CW'(1);
                if (draw_done) begin
                    state_d = S_SEL;
                end else if (cnt_q == CNT_LAST) begin
                    tout_d  = 1'b1;
                    state_d = S_SEL;
                end
            end
            S_UPDATE: begin
                game_update = 1'b1;
                state_d     = S_SAMPLE;
            end
            S_SAMPLE: begin
                cur_d   = obj_active;
                todo_d  = obj_active;
                pass_d  = PASS_PAINT;
                state_d = S_SEL;
            end
            S_FEND: begin
                frame_done = 1'b1;
                prev_d     = cur_q;
                state_d    = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q   <= S_IDLE;
            pass_q    <= PASS_PAINT;
            prev_q    <= '0;
            cur_q     <= '0;
            todo_q    <= '0;
            sel_q     <= OBJ_NONE;
            cnt_q     <= '0;
            pending_q <= 1'b0;
            overrun_q <= 1'b0;
            tout_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            pass_q    <= pass_d;
            prev_q    <= prev_d;
            cur_q     <= cur_d;
            todo_q    <= todo_d;
            sel_q     <= sel_d;
            cnt_q     <= cnt_d;
            pending_q <= pending_d;
            overrun_q <= overrun_d;
            tout_q    <= tout_d;
        end
    end

    assign erase       = (pass_q == PASS_ERASE) && (state_q != S_IDLE);
    assign busy        = (state_q != S_IDLE);
    assign overrun     = overrun_q;
    assign timeout_err = tout_q;

endmodule

// File: tb/tb_draw_sequencer.sv
// tb_draw_sequencer: randomized frame-level bench for draw_sequencer.
// Expected loads, pass lengths and flags come from a per-frame model.
module tb_draw_sequencer;

    localparam int TO = 8;

    logic       clk = 1'b0;
    logic       reset;
    logic       frame_tick;
    logic [4:0] obj_active;
    logic       draw_done;
    logic [3:0] control_signal;
    logic       enable_load;
    logic       enable_draw;
    logic       erase;
    logic       game_update;
    logic       frame_done;
    logic       busy;
    logic       overrun;
    logic       timeout_err;

    always #5 clk = ~clk;

    draw_sequencer #(.TIMEOUT_CYCLES(TO)) dut (
        .clk            (clk),
        .reset          (reset),
        .frame_tick     (frame_tick),
        .obj_active     (obj_active),
        .draw_done      (draw_done),
        .control_signal (control_signal),
        .enable_load    (enable_load),
        .enable_draw    (enable_draw),
        .erase          (erase),
        .game_update    (game_update),
        .frame_done     (frame_done),
        .busy           (busy),
        .overrun        (overrun),
        .timeout_err    (timeout_err)
    );

    int n_cmp = 0;
    int n_bad = 0;

    bit [4:0] m_prev;
    bit       m_to;
    bit       m_ovr;

    task automatic check(input string tag, input logic [31:0] obs,
                         input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic int popc(input bit [4:0] m);
        int n = 0;
        for (int i = 0; i < 5; i++) n += int'(m[i]);
        return n;
    endfunction

    task automatic check_all_zero(input string tag);
        check({tag, "_ctrl"}, control_signal, 0);
        check({tag, "_load"}, enable_load, 0);
        check({tag, "_draw"}, enable_draw, 0);
        check({tag, "_erase"}, erase, 0);
        check({tag, "_upd"}, game_update, 0);
        check({tag, "_fdone"}, frame_done, 0);
        check({tag, "_busy"}, busy, 0);
        check({tag, "_ovr"}, overrun, 0);
        check({tag, "_tout"}, timeout_err, 0);
    endtask

    // One whole frame. do_tick=0 relies on a queued tick.
    // xt1/xt2: frame cycles in which to raise an extra tick.
    // fixd: fixed draw delay for every object (0 = random).
    task automatic run_frame(input bit do_tick, input bit [4:0] new_mask,
                             input int xt1, input int xt2, input int fixd);
        int       dq[$];
        bit [3:0] codes[$];
        bit       ers[$];
        int       exp_len;
        int       loads;
        int       cnt;
        int       d;
        int       eff;
        bit       done;
        bit       prev_draw;

        for (int i = 0; i < 5; i++)
            if (m_prev[i]) begin
                codes.push_back(4'(i + 1));
                ers.push_back(1'b1);
            end
        for (int i = 0; i < 5; i++)
            if (new_mask[i]) begin
                codes.push_back(4'(i + 1));
                ers.push_back(1'b0);
            end
        exp_len = 5;
        for (int i = 0; i < codes.size(); i++) begin
            if (fixd > 0) d = fixd;
            else if ($urandom_range(0, 7) == 0) d = 30;
            else d = int'($urandom_range(1, 6));
            dq.push_back(d);
            exp_len += ((d > TO) ? TO : d) + 2;
            if (d > TO) m_to = 1'b1;
        end
        if (xt2 > 0) m_ovr = 1'b1;

        @(posedge clk); #1;
        check("idle_gap_busy", busy, 0);
        obj_active = 5'($urandom);
        frame_tick = do_tick;
        loads = 0; cnt = 0; d = 0; eff = 0;
        done = 1'b0; prev_draw = 1'b0;

        for (int cyc = 1; cyc <= 3000 && !done; cyc++) begin
            @(posedge clk); #1;
            frame_tick = (cyc == xt1 || cyc == xt2);
            draw_done = 1'b0;
            if (cyc == 1) check("start_busy", busy, 1);
            if (prev_draw && !enable_draw)
                check("draw_len", cnt, eff);
            if (enable_load) begin
                if (loads == 0)
                    check("first_load_cyc", cyc, (m_prev != 0) ? 2 : 5);
                if (loads < codes.size()) begin
                    check("load_code", control_signal, codes[loads]);
                    check("load_erase", erase, ers[loads]);
                    d = dq[loads];
                    eff = (d > TO) ? TO : d;
                end else begin
                    check("load_count", loads + 1, codes.size());
                end
                loads++;
                cnt = 0;
                draw_done = 1'($urandom_range(0, 1));
            end else if (enable_draw) begin
                cnt++;
                if (cnt == d) draw_done = 1'b1;
            end
            prev_draw = enable_draw;
            if (game_update) begin
                check("upd_after_erase", loads, popc(m_prev));
                check("upd_ctrl", control_signal, 0);
                obj_active = new_mask;
            end
            if (frame_done) begin
                check("frame_len", cyc, exp_len);
                check("loads_total", loads, codes.size());
                check("fend_erase", erase, 0);
                done = 1'b1;
            end
        end
        frame_tick = 1'b0;
        draw_done = 1'b0;
        check("frame_done_seen", done, 1);
        check("timeout_err", timeout_err, m_to);
        check("overrun", overrun, m_ovr);
        m_prev = new_mask;
    endtask

    initial begin
        reset = 1'b0;
        frame_tick = 1'b0;
        draw_done = 1'b0;
        obj_active = 5'b0;
        m_prev = 5'b0; m_to = 1'b0; m_ovr = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check_all_zero("reset");
        reset = 1'b1;

        run_frame(1'b1, 5'b00011, 0, 0, 4);
        run_frame(1'b1, 5'b00001, 0, 0, 4);
        run_frame(1'b1, 5'b00101, 0, 0, 30);

        run_frame(1'b1, 5'b00110, 3, 0, 0);
        run_frame(1'b0, 5'b01001, 0, 0, 0);
        run_frame(1'b1, 5'b10001, 3, 6, 0);
        run_frame(1'b0, 5'b00011, 0, 0, 0);

        @(posedge clk); #1;
        draw_done = 1'b1;
        @(posedge clk); #1;
        draw_done = 1'b0;
        check("stray_idle_busy", busy, 0);
        check("stray_idle_load", enable_load, 0);

        for (int f = 0; f < 8; f++)
            run_frame(1'b1, 5'($urandom), 0, 0, 0);

        run_frame(1'b1, 5'b11111, 0, 0, 0);
        @(posedge clk); #1;
        frame_tick = 1'b1;
        @(posedge clk); #1;
        frame_tick = 1'b0;
        for (int i = 0; i < 50 && !enable_draw; i++) begin
            @(posedge clk); #1;
        end
        check("rst_saw_draw", enable_draw, 1);
        @(posedge clk); #1;
        reset = 1'b0;
        @(posedge clk); #1;
        reset = 1'b1;
        check_all_zero("rst_mid");
        m_prev = 5'b0; m_to = 1'b0; m_ovr = 1'b0;
        run_frame(1'b1, 5'b10110, 0, 0, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 n_cmp, n_bad);
        $finish;
    end

endmodule
